hub75_gif_sequencer: RTL and testbench

Playback controller for the HUB75 32x32 GIF player. It owns the current frame index and the ROM base address, and sequences animation advance from the scan engine's end-of-refresh pulse. It adds play/pause, single-frame step forward/back and a run-time speed control. It sits between the user-command logic and the scan FSM, which consumes `base_addr` to address `gif_rom`. All frame changes occur only at refresh boundaries, so a displayed refresh never mixes frames.

---
 rtl/hub75_gif_sequencer.sv | 77 +++++++
 tb/tb_hub75_gif_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hub75_gif_sequencer.sv
// hub75_gif_sequencer: HUB75 GIF playback sequencer; define HUB75_SEQ_PINGPONG_EN for bounce auto-advance
module hub75_gif_sequencer #(
  parameter int NUM_FRAMES     = 60,
  parameter int FRAME_PIX_LOG2 = 10,
  parameter int ADDR_W         = 16,
  parameter int HOLD_DEFAULT   = 64,
  parameter int HOLD_MIN       = 8,
  parameter int HOLD_MAX       = 248,
  parameter int HOLD_STEP      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              refresh_done,
  input  logic              cmd_play_toggle,
  input  logic              cmd_next,
  input  logic              cmd_prev,
  input  logic              cmd_faster,
  input  logic              cmd_slower,
  output logic [5:0]        frame_idx,
  output logic [ADDR_W-1:0] base_addr,
  output logic              frame_changed,
  output logic              playing,
  output logic [7:0]        hold_val
);
  typedef enum logic {PAUSE, PLAY} state_t;
  typedef enum logic [1:0] {NONE, INC, DEC} step_t;
  localparam logic [5:0] LAST = 6'(NUM_FRAMES - 1);
  state_t state;
  step_t step_pend, step_now;
  logic [7:0] hold_cnt;
  logic [5:0] fwd, bwd, auto_nxt, nxt;
  logic step_adv, auto_adv;
  assign playing = state == PLAY;
  assign fwd = frame_idx == LAST ? 6'd0 : frame_idx + 6'd1;
  assign bwd = frame_idx == 6'd0 ? LAST : frame_idx - 6'd1;
`ifdef HUB75_SEQ_PINGPONG_EN
  logic dir;
  assign auto_nxt = dir ? (frame_idx == LAST ? LAST - 6'd1 : frame_idx + 6'd1)
                        : (frame_idx == 6'd0 ? 6'd1 : frame_idx - 6'd1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dir <= 1'b1;
    else if (auto_adv) dir <= dir ? frame_idx != LAST : frame_idx == 6'd0;
  end
`else
  assign auto_nxt = fwd;
`endif
  always_comb begin
    step_now = cmd_next && !cmd_prev ? INC : cmd_prev && !cmd_next ? DEC : step_pend;
    step_adv = refresh_done && step_now != NONE;
    auto_adv = refresh_done && step_now == NONE && state == PLAY && hold_cnt >= hold_val - 8'd1;
    nxt = step_now == INC ? fwd : step_now == DEC ? bwd : auto_nxt;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= PLAY;
      step_pend     <= NONE;
      hold_cnt      <= '0;
      hold_val      <= 8'(HOLD_DEFAULT);
      frame_idx     <= '0;
      base_addr     <= '0;
      frame_changed <= 1'b0;
    end else begin
      frame_changed <= step_adv || auto_adv;
      if (step_adv || auto_adv) begin
        frame_idx <= nxt;
        base_addr <= ADDR_W'(nxt) << FRAME_PIX_LOG2;
      end
      hold_cnt  <= step_adv || auto_adv ? 8'd0 : refresh_done && state == PLAY ? hold_cnt + 8'd1 : hold_cnt;
      step_pend <= refresh_done ? NONE : step_now;
      if (cmd_play_toggle) state <= state == PLAY ? PAUSE : PLAY;
      if (cmd_faster && !cmd_slower)
        hold_val <= hold_val < 8'(HOLD_MIN + HOLD_STEP) ? 8'(HOLD_MIN) : hold_val - 8'(HOLD_STEP);
      else if (cmd_slower && !cmd_faster)
        hold_val <= hold_val > 8'(HOLD_MAX - HOLD_STEP) ? 8'(HOLD_MAX) : hold_val + 8'(HOLD_STEP);
    end
  end
endmodule

// File: tb/tb_hub75_gif_sequencer.sv
// tb_hub75_gif_sequencer: scoreboard bench with a frame-level playback model
module tb_hub75_gif_sequencer;
  localparam int NF = 60;
  localparam logic [5:0] RD = 6'd1, TG = 6'd2, NX = 6'd4, PV = 6'd8, FA = 6'd16, SL = 6'd32;
  logic clk = 0, reset_n = 0;
  logic refresh_done = 0, cmd_play_toggle = 0, cmd_next = 0, cmd_prev = 0, cmd_faster = 0, cmd_slower = 0;
  logic [5:0] frame_idx;
  logic [15:0] base_addr;
  logic frame_changed, playing;
  logic [7:0] hold_val;
  int n_chk = 0, n_fail = 0;
  int m_frame, m_hold, m_cnt, m_pend;
  bit m_play, m_dir;
  int exp_q[$];

  hub75_gif_sequencer dut (
    .clk(clk), .reset_n(reset_n), .refresh_done(refresh_done), .cmd_play_toggle(cmd_play_toggle),
    .cmd_next(cmd_next), .cmd_prev(cmd_prev), .cmd_faster(cmd_faster), .cmd_slower(cmd_slower),
    .frame_idx(frame_idx), .base_addr(base_addr), .frame_changed(frame_changed),
    .playing(playing), .hold_val(hold_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame = 0; m_play = 1; m_hold = 64; m_cnt = 0; m_pend = 0; m_dir = 1;
    exp_q.delete();
  endtask

  // Playback rules in frame arithmetic: modular manual steps, hold counting, saturating speed.
  task automatic model(input logic [5:0] v);
    int s;
    bit chg;
    chg = 0;
    s = (v[2] && !v[3]) ? 1 : (v[3] && !v[2]) ? -1 : m_pend;
    if (v[0]) begin
      if (s != 0) begin
        m_frame = (m_frame + s + NF) % NF; m_cnt = 0; chg = 1;
      end else if (m_play) begin
        if (m_cnt + 1 >= m_hold) begin
`ifdef HUB75_SEQ_PINGPONG_EN
          if (m_frame == NF - 1 && m_dir) m_dir = 0;
          else if (m_frame == 0 && !m_dir) m_dir = 1;
          m_frame += m_dir ? 1 : -1;
`else
          m_frame = (m_frame + 1) % NF;
`endif
          m_cnt = 0; chg = 1;
        end else m_cnt++;
      end
      m_pend = 0;
    end else m_pend = s;
    if (v[1]) m_play = !m_play;
    if (v[4] && !v[5]) m_hold = (m_hold - 8 < 8) ? 8 : m_hold - 8;
    if (v[5] && !v[4]) m_hold = (m_hold + 8 > 248) ? 248 : m_hold + 8;
    if (chg) exp_q.push_back(m_frame);
  endtask

  task automatic cycle(input logic [5:0] v);
    @(negedge clk);
    {cmd_slower, cmd_faster, cmd_prev, cmd_next, cmd_play_toggle, refresh_done} = v;
    model(v);
    @(posedge clk);
    #1;
    {cmd_slower, cmd_faster, cmd_prev, cmd_next, cmd_play_toggle, refresh_done} = '0;
  endtask

  task automatic cycles(input int n, input logic [5:0] v);
    for (int i = 0; i < n; i++) cycle(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    model_reset();
    #1;
    chk("async_rst_frame", frame_idx, 0);
    chk("async_rst_addr", base_addr, 0);
    chk("async_rst_fc", frame_changed, 0);
    chk("async_rst_play", playing, 1);
    chk("async_rst_hold", hold_val, 64);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        if (frame_changed) begin
          if (exp_q.size() == 0) chk("unexpected_frame_changed", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("sb_frame_idx", frame_idx, e);
            chk("sb_base_addr", base_addr, e * 1024);
          end
        end
        chk("track_frame", frame_idx, m_frame);
        chk("track_playing", playing, m_play);
        chk("track_hold", hold_val, m_hold);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] v;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame", frame_idx, 0);
    chk("rst_addr", base_addr, 0);
    chk("rst_fc", frame_changed, 0);
    chk("rst_playing", playing, 1);
    chk("rst_hold", hold_val, 64);
    @(negedge clk);
    reset_n = 1;
    cycles(63, RD);
    chk("hold63_frame", frame_idx, 0);
    cycle(RD);
    chk("hold64_frame", frame_idx, 1);
    chk("hold64_addr", base_addr, 16'h0400);
    chk("hold64_fc", frame_changed, 1);
    cycle(0);
    chk("fc_one_cycle", frame_changed, 0);
    cycles(58, RD | NX);
    chk("step_to_59", frame_idx, 59);
    cycles(64, RD);
    chk("wrap_frame", frame_idx, 0);
    chk("wrap_addr", base_addr, 0);
    cycle(TG);
    chk("pause", playing, 0);
    cycle(PV);
    chk("prev_before_refresh", frame_idx, 0);
    cycle(RD);
    chk("prev_wrap", frame_idx, 59);
    cycles(100, RD);
    chk("pause_hold", frame_idx, 59);
    cycles(10, FA);
    chk("faster_sat", hold_val, 8);
    cycles(40, SL);
    chk("slower_sat", hold_val, 248);
    cycle(TG);
    cycles(30, RD);
    cycles(30, FA);
    chk("speed_shrunk", hold_val, 8);
    chk("cnt30_no_adv", frame_idx, 59);
    cycle(RD);
    chk("cnt30_force_adv", frame_idx, 0);
    cycle(TG);
    cycle(NX | PV);
    cycle(RD);
    chk("next_prev_ignored", frame_idx, 0);
    cycle(TG);
    cycles(3, RD);
    cycle(NX);
    cycle(PV);
    cycle(RD);
    chk("latest_step_wins", frame_idx, 59);
    cycles(7, RD);
    chk("cnt_cleared_7", frame_idx, 59);
    cycle(RD);
    chk("cnt_cleared_8", frame_idx, 0);
    cycles(7, RD);
    cycle(RD | TG);
    chk("toggle_boundary_frame", frame_idx, 1);
    chk("toggle_boundary_play", playing, 0);
    cycle(TG);
    cycles(3, RD);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = '0;
      v[0] = $urandom_range(2) == 0;
      v[1] = $urandom_range(40) == 0;
      v[2] = $urandom_range(15) == 0;
      v[3] = $urandom_range(15) == 0;
      v[4] = $urandom_range(10) == 0;
      v[5] = $urandom_range(12) == 0;
      if (i == 1500) do_reset();
      else cycle(v);
    end
    cycle(0);
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
